// File: rtl/regfile_sb.sv
// +----------------------------------------------------------------------+
// | regfile_sb : 2R/1W register file with clear sequencer and scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_a_index,
  output logic [DATA_WIDTH-1:0] read_a_data,
  output logic                  read_a_pending,
  input  logic [ADDR_WIDTH-1:0] read_b_index,
  output logic [DATA_WIDTH-1:0] read_b_data,
  output logic                  read_b_pending,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_index,
  output logic                  ready,
  output logic                  wr_zero_err
);

  localparam int                    c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clear_cnt;
  logic [DATA_WIDTH-1:0]   r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]      r_pending;
  logic                    r_wr_zero_err;

  logic                    w_ready;
  logic                    w_wr_zero;
  logic                    w_wr_ok;
  logic                    w_rsv_ok;

  assign w_ready   = (r_state == ST_RUN);
  assign w_wr_zero = w_ready && write_enable && (ZERO_REG != 0) && (write_index == '0);
  assign w_wr_ok   = w_ready && write_enable && !((ZERO_REG != 0) && (write_index == '0));
  assign w_rsv_ok  = w_ready && reserve_en && !((ZERO_REG != 0) && (reserve_index == '0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clear_cnt == c_LAST) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clear_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clear_cnt <= r_clear_cnt + 1'b1;
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) r_regs[r_clear_cnt] <= '0;
      else if (w_wr_ok)        r_regs[write_index] <= write_data;
    end
  end

  // Reserve is applied after the write so a new producer wins on the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_wr_zero_err <= 1'b0;
    end else begin
      if (w_wr_ok)  r_pending[write_index]   <= 1'b0;
      if (w_rsv_ok) r_pending[reserve_index] <= 1'b1;
      r_wr_zero_err <= w_wr_zero;
    end
  end

  logic [ADDR_WIDTH-1:0] w_rd_idx  [2];
  logic [DATA_WIDTH-1:0] w_rd_data [2];
  logic                  w_rd_pend [2];

  assign w_rd_idx[0] = read_a_index;
  assign w_rd_idx[1] = read_b_index;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic w_zero;
    logic w_hit;
    assign w_zero       = (ZERO_REG != 0) && (w_rd_idx[p] == '0);
    assign w_hit        = (BYPASS != 0) && w_wr_ok && (write_index == w_rd_idx[p]);
    assign w_rd_data[p] = (!w_ready || w_zero) ? '0 :
                          w_hit ? write_data : r_regs[w_rd_idx[p]];
    assign w_rd_pend[p] = w_ready && !w_zero && !w_hit && r_pending[w_rd_idx[p]];
  end

  assign read_a_data    = w_rd_data[0];
  assign read_a_pending = w_rd_pend[0];
  assign read_b_data    = w_rd_data[1];
  assign read_b_pending = w_rd_pend[1];
  assign ready          = w_ready;
  assign wr_zero_err    = r_wr_zero_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// +----------------------------------------------------------------------+
// | tb_regfile_sb : bypass and non-bypass instances against a model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_regfile_sb;

  localparam int c_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra = '0, rb = '0, wi = '0, ri = '0;
  logic        we = 1'b0, res = 1'b0;
  logic [31:0] wd = '0;

  logic [31:0] a_data_b, b_data_b, a_data_n, b_data_n;
  logic        a_pend_b, b_pend_b, a_pend_n, b_pend_n;
  logic        rdy_b, rdy_n, err_b, err_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .read_a_index(ra), .read_a_data(a_data_b), .read_a_pending(a_pend_b),
    .read_b_index(rb), .read_b_data(b_data_b), .read_b_pending(b_pend_b),
    .write_index(wi), .write_enable(we), .write_data(wd),
    .reserve_en(res), .reserve_index(ri),
    .ready(rdy_b), .wr_zero_err(err_b));

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .clk(clk), .rst(rst),
    .read_a_index(ra), .read_a_data(a_data_n), .read_a_pending(a_pend_n),
    .read_b_index(rb), .read_b_data(b_data_n), .read_b_pending(b_pend_n),
    .write_index(wi), .write_enable(we), .write_data(wd),
    .reserve_en(res), .reserve_index(ri),
    .ready(rdy_n), .wr_zero_err(err_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural register contents, pending set, clear cycles remaining.
  logic [31:0] m_regs [c_DEPTH];
  logic        m_pend [c_DEPTH];
  int          m_clear_left = c_DEPTH;
  logic        m_err = 1'b0;
  logic        m_valid = 1'b0;

  function automatic logic m_ready();
    return m_clear_left == 0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] idx, input bit byp);
    if (!m_ready() || idx == 0) return 32'h0;
    if (byp && we && wi == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic logic exp_pend(input logic [4:0] idx, input bit byp);
    if (!m_ready() || idx == 0) return 1'b0;
    if (byp && we && wi == idx) return 1'b0;
    return m_pend[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid      = 1'b1;
      m_clear_left = c_DEPTH;
      m_err        = 1'b0;
      for (int i = 0; i < c_DEPTH; i++) m_pend[i] = 1'b0;
    end else if (!m_ready()) begin
      m_regs[c_DEPTH - m_clear_left] = 32'h0;
      m_clear_left--;
      m_err = 1'b0;
    end else begin
      m_err = we && (wi == 0);
      if (we && wi != 0) begin
        m_regs[wi] = wd;
        m_pend[wi] = 1'b0;
      end
      if (res && ri != 0) m_pend[ri] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_byp",   {31'b0, rdy_b},    {31'b0, m_ready()});
      chk("ready_nb",    {31'b0, rdy_n},    {31'b0, m_ready()});
      chk("zerr_byp",    {31'b0, err_b},    {31'b0, m_err});
      chk("zerr_nb",     {31'b0, err_n},    {31'b0, m_err});
      chk("a_data_byp",  a_data_b,          exp_data(ra, 1'b1));
      chk("b_data_byp",  b_data_b,          exp_data(rb, 1'b1));
      chk("a_data_nb",   a_data_n,          exp_data(ra, 1'b0));
      chk("b_data_nb",   b_data_n,          exp_data(rb, 1'b0));
      chk("a_pend_byp",  {31'b0, a_pend_b}, {31'b0, exp_pend(ra, 1'b1)});
      chk("b_pend_byp",  {31'b0, b_pend_b}, {31'b0, exp_pend(rb, 1'b1)});
      chk("a_pend_nb",   {31'b0, a_pend_n}, {31'b0, exp_pend(ra, 1'b0)});
      chk("b_pend_nb",   {31'b0, b_pend_n}, {31'b0, exp_pend(rb, 1'b0)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    chk("lit_ready_after_rst", {31'b0, rdy_b}, 32'h0);

    // Restart the clear sequence part-way through.
    repeat (10) tick();
    chk("lit_ready_midclear", {31'b0, rdy_b}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Second clear: count ready, and poke r9 during clear cycle 2.
    for (int i = 0; i < c_DEPTH; i++) begin
      chk("lit_ready_low", {31'b0, rdy_b}, 32'h0);
      if (i == 2) begin
        we = 1'b1; wi = 5'd9; wd = 32'h55; res = 1'b1; ri = 5'd9;
      end else begin
        we = 1'b0; res = 1'b0;
      end
      tick();
    end
    we = 1'b0; res = 1'b0;
    chk("lit_ready_high", {31'b0, rdy_b}, 32'h1);

    for (int i = 0; i < c_DEPTH; i++) begin
      ra = 5'(i); rb = 5'(c_DEPTH - 1 - i);
      #1;
      chk("lit_clear_data", a_data_b, 32'h0);
      chk("lit_clear_pend", {31'b0, a_pend_b}, 32'h0);
      tick();
    end

    // Basic write then dual read.
    we = 1'b1; wi = 5'd5; wd = 32'hDEADBEEF; ra = 5'd9; rb = 5'd9;
    tick();
    we = 1'b0; ra = 5'd5; rb = 5'd5;
    #1;
    chk("lit_r5_a", a_data_b, 32'hDEADBEEF);
    chk("lit_r5_b", b_data_b, 32'hDEADBEEF);
    tick();

    // Write to r0: ignored, error pulse for one cycle.
    we = 1'b1; wi = 5'd0; wd = 32'h1; ra = 5'd0;
    tick();
    we = 1'b0;
    #1;
    chk("lit_zerr_pulse", {31'b0, err_b}, 32'h1);
    chk("lit_r0_data", a_data_b, 32'h0);
    tick();
    chk("lit_zerr_drop", {31'b0, err_b}, 32'h0);

    // Bypass versus non-bypass.
    we = 1'b1; wi = 5'd7; wd = 32'h1234; ra = 5'd7;
    #1;
    chk("lit_bypass", a_data_b, 32'h1234);
    chk("lit_nobypass_old", a_data_n, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("lit_nobypass_new", a_data_n, 32'h1234);
    tick();

    // Scoreboard.
    res = 1'b1; ri = 5'd3; rb = 5'd3;
    tick();
    res = 1'b0;
    #1;
    chk("lit_pend_set", {31'b0, b_pend_b}, 32'h1);
    we = 1'b1; wi = 5'd3; wd = 32'hAA;
    #1;
    chk("lit_pend_bypass_clr", {31'b0, b_pend_b}, 32'h0);
    chk("lit_pend_nb_held", {31'b0, b_pend_n}, 32'h1);
    tick();
    we = 1'b0;
    #1;
    chk("lit_pend_nb_clr", {31'b0, b_pend_n}, 32'h0);
    we = 1'b1; wi = 5'd3; wd = 32'hAA; res = 1'b1; ri = 5'd3;
    tick();
    we = 1'b0; res = 1'b0;
    #1;
    chk("lit_pend_rsv_wins", {31'b0, b_pend_b}, 32'h1);
    chk("lit_data_rsv_wr", b_data_b, 32'hAA);
    res = 1'b1; ri = 5'd0; ra = 5'd0;
    tick();
    res = 1'b0;
    #1;
    chk("lit_r0_no_pend", {31'b0, a_pend_b}, 32'h0);

    // Mixed directed traffic checked by the model every cycle.
    for (int i = 1; i < 24; i++) begin
      we  = (i % 3) != 0;
      wi  = 5'((i * 7) % c_DEPTH);
      wd  = 32'h01010101 * i;
      res = (i % 4) == 1;
      ri  = 5'((i * 11) % c_DEPTH);
      ra  = 5'((i * 7) % c_DEPTH);
      rb  = 5'((i * 11 + 1) % c_DEPTH);
      tick();
    end
    we = 1'b0; res = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write register file.
- Configurable data width and depth; register 0 optionally hardwired to zero.
- Adds a post-reset hardware clear sequencer, optional write-to-read bypass, and a per-register pending (scoreboard) bit for a pipelined core's decode stage.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH  32  width of each register
ADDR_WIDTH  5   index width; DEPTH = 2**ADDR_WIDTH registers
BYPASS      1   1 = same-cycle write data forwarded to read ports
ZERO_REG    1   1 = register 0 reads 0 and ignores writes/reservations

Ports:
clk             in   1           clock, all state on rising edge
rst             in   1           synchronous active-high reset
read_a_index    in   ADDR_WIDTH  read port A index
read_a_data     out  DATA_WIDTH  read port A data (combinational)
read_a_pending  out  1           register at read_a_index awaits writeback
read_b_index    in   ADDR_WIDTH  read port B index
read_b_data     out  DATA_WIDTH  read port B data (combinational)
read_b_pending  out  1           register at read_b_index awaits writeback
write_index     in   ADDR_WIDTH  write index
write_enable    in   1           write strobe
write_data      in   DATA_WIDTH  write data
reserve_en      in   1           mark register pending (issue of producer)
reserve_index   in   ADDR_WIDTH  register to reserve
ready           out  1           1 = clear done, ports live
wr_zero_err     out  1           one-cycle pulse: write attempted to reg 0

Behaviour:
- FSM states CLEAR, RUN. rst (any cycle, incl. mid-clear) -> CLEAR, clear_cnt<=0, all pending bits<=0, wr_zero_err<=0.
- CLEAR: each cycle regs[clear_cnt]<=0, clear_cnt++. Cycle writing DEPTH-1 -> RUN next edge. Exactly DEPTH cycles after rst deasserts, ready=1.
- ready = (state==RUN); reset value 0. CLEAR ignores write_enable/reserve_en; read data 0, pending 0.
- RUN write: write_enable & index!=0 (or ZERO_REG=0) -> regs[write_index]<=write_data at edge, pending[write_index]<=0.
- Write to index 0 with ZERO_REG=1: no state change; wr_zero_err=1 the following cycle only (registered).
- Reserve: reserve_en -> pending[reserve_index]<=1. Ignored for index 0 when ZERO_REG=1.
- Reserve and write same index same cycle: data written, pending ends 1 (new producer wins).
- Read: index 0 & ZERO_REG=1 -> data 0, pending 0. Otherwise data = regs[idx], pending = pending[idx].
- BYPASS=1 & write hit (write_enable, ready, write_index==read idx, idx writable): data=write_data, pending=0 same cycle. BYPASS=0: old value until next edge, pending cleared after edge.
- Both read ports independent; same index on A and B returns identical values.
- No write-enable -> registers hold indefinitely.

Test Plan:
- Reset/clear: DEPTH=32; pulse rst 1 cycle -> ready=0 for 32 cycles, 1 on cycle 33; every index reads 0, pending 0.
- Mid-clear reset: assert rst at clear cycle 10 -> counter restarts; ready rises 32 cycles after the second rst drops.
- Write/read: write 0xDEADBEEF to r5; next cycle read_a_index=5, read_b_index=5 -> both 0xDEADBEEF. Write 0x1 to r0 -> r0 reads 0, wr_zero_err=1 exactly one cycle.
- Bypass: BYPASS=1, write 0x1234 to r7 with read_a_index=7 same cycle -> read_a_data=0x1234 that cycle. BYPASS=0 -> old value that cycle, 0x1234 next.
- Scoreboard: reserve r3 -> read_b_pending=1 next cycle. Write r3=0xAA -> pending 0 after the edge, or same cycle with BYPASS. Reserve and write r3 same cycle -> pending stays 1, data 0xAA.
- Ignored during CLEAR: write r9=0x55 and reserve r9 at clear cycle 2 -> after ready, r9=0, pending 0.
